// File: rtl/orc_r32i_core.sv
// Multi-cycle RV32I core: FETCH -> EXECUTE -> (LOAD) -> FETCH over separate fetch, load and store ports.
// Fetch and load requests are registered and held until acked; stores are a one-cycle posted strobe.
module orc_r32i_core #(
  parameter logic [31:0] P_RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        o_inst_read,
  input  logic        i_inst_read_ack,
  output logic [31:0] o_inst_read_addr,
  input  logic [31:0] i_inst_read_data,
  output logic        o_master_read,
  input  logic        i_master_read_ack,
  output logic [31:0] o_master_read_addr,
  input  logic [31:0] i_master_read_data,
  output logic        o_master_write,
  input  logic        i_master_write_ack,
  output logic [31:0] o_master_write_addr,
  output logic [31:0] o_master_write_data,
  output logic [3:0]  o_master_write_byte_enable
);

  typedef enum logic [1:0] {S_FETCH, S_EXECUTE, S_LOAD} state_t;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        inst_read_q, inst_read_d;
  logic [31:0] inst_addr_q, inst_addr_d;
  logic        mem_read_q, mem_read_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] rf_q [32];

  logic        rf_we;
  logic [31:0] rf_wdata;
  logic        wr_en;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_be;
  logic        unused_write_ack;

  assign unused_write_ack = i_master_write_ack;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;

  assign opcode  = ir_q[6:0];
  assign rd      = ir_q[11:7];
  assign f3      = ir_q[14:12];
  assign rs1     = ir_q[19:15];
  assign rs2     = ir_q[24:20];
  assign imm_i   = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s   = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b   = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u   = {ir_q[31:12], 12'h000};
  assign imm_j   = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  assign rs1_val = (rs1 == 5'd0) ? 32'h0 : rf_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'h0 : rf_q[rs2];

  logic [31:0] alu_b, alu_res;
  logic        br_taken;

  always_comb begin
    alu_b   = (opcode == OPC_OP) ? rs2_val : imm_i;
    alu_res = 32'h0;
    case (f3)
      3'b000: alu_res = (opcode == OPC_OP && ir_q[30]) ? rs1_val - alu_b : rs1_val + alu_b;
      3'b001: alu_res = rs1_val << alu_b[4:0];
      3'b010: alu_res = {31'h0, $signed(rs1_val) < $signed(alu_b)};
      3'b011: alu_res = {31'h0, rs1_val < alu_b};
      3'b100: alu_res = rs1_val ^ alu_b;
      3'b101: alu_res = ir_q[30] ? 32'($signed(rs1_val) >>> alu_b[4:0]) : rs1_val >> alu_b[4:0];
      3'b110: alu_res = rs1_val | alu_b;
      default: alu_res = rs1_val & alu_b;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (f3)
      3'b000: br_taken = rs1_val == rs2_val;
      3'b001: br_taken = rs1_val != rs2_val;
      3'b100: br_taken = $signed(rs1_val) < $signed(rs2_val);
      3'b101: br_taken = $signed(rs1_val) >= $signed(rs2_val);
      3'b110: br_taken = rs1_val < rs2_val;
      3'b111: br_taken = rs1_val >= rs2_val;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    inst_read_d = inst_read_q;
    inst_addr_d = inst_addr_q;
    mem_read_d  = mem_read_q;
    mem_addr_d  = mem_addr_q;
    rf_we       = 1'b0;
    rf_wdata    = 32'h0;
    wr_en       = 1'b0;
    wr_addr     = 32'h0;
    wr_data     = 32'h0;
    wr_be       = 4'h0;
    case (state_q)
      S_FETCH: begin
        // Acks only count against a request we actually have on the bus.
        if (inst_read_q && i_inst_read_ack) begin
          ir_d        = i_inst_read_data;
          inst_read_d = 1'b0;
          state_d     = S_EXECUTE;
        end else if (!inst_read_q) begin
          inst_read_d = 1'b1;
          inst_addr_d = pc_q;
        end
      end
      S_EXECUTE: begin
        pc_d    = pc_q + 32'd4;
        state_d = S_FETCH;
        case (opcode)
          OPC_LUI:   begin rf_we = 1'b1; rf_wdata = imm_u; end
          OPC_AUIPC: begin rf_we = 1'b1; rf_wdata = pc_q + imm_u; end
          OPC_OP, OPC_OPIMM: begin rf_we = 1'b1; rf_wdata = alu_res; end
          OPC_JAL: begin
            rf_we = 1'b1; rf_wdata = pc_q + 32'd4; pc_d = pc_q + imm_j;
          end
          OPC_JALR: begin
            rf_we = 1'b1; rf_wdata = pc_q + 32'd4; pc_d = (rs1_val + imm_i) & ~32'd1;
          end
          OPC_BRANCH: if (br_taken) pc_d = pc_q + imm_b;
          OPC_STORE: begin
            wr_en   = 1'b1;
            wr_addr = rs1_val + imm_s;
            case (f3[1:0])
              2'b00:   begin wr_data = {24'h0, rs2_val[7:0]};  wr_be = 4'b0001; end
              2'b01:   begin wr_data = {16'h0, rs2_val[15:0]}; wr_be = 4'b0011; end
              default: begin wr_data = rs2_val;                wr_be = 4'b1111; end
            endcase
          end
          OPC_LOAD: begin
            state_d    = S_LOAD;
            pc_d       = pc_q;
            mem_read_d = 1'b1;
            mem_addr_d = rs1_val + imm_i;
          end
          default: ;
        endcase
        if (state_d == S_FETCH) begin
          inst_read_d = 1'b1;
          inst_addr_d = pc_d;
        end
      end
      S_LOAD: begin
        if (mem_read_q && i_master_read_ack) begin
          rf_we = 1'b1;
          case (f3)
            3'b000:  rf_wdata = {{24{i_master_read_data[7]}}, i_master_read_data[7:0]};
            3'b001:  rf_wdata = {{16{i_master_read_data[15]}}, i_master_read_data[15:0]};
            3'b100:  rf_wdata = {24'h0, i_master_read_data[7:0]};
            3'b101:  rf_wdata = {16'h0, i_master_read_data[15:0]};
            default: rf_wdata = i_master_read_data;
          endcase
          mem_read_d  = 1'b0;
          pc_d        = pc_q + 32'd4;
          state_d     = S_FETCH;
          inst_read_d = 1'b1;
          inst_addr_d = pc_q + 32'd4;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_FETCH;
      pc_q        <= P_RESET_PC;
      ir_q        <= 32'h0;
      inst_read_q <= 1'b0;
      inst_addr_q <= 32'h0;
      mem_read_q  <= 1'b0;
      mem_addr_q  <= 32'h0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      inst_read_q <= inst_read_d;
      inst_addr_q <= inst_addr_d;
      mem_read_q  <= mem_read_d;
      mem_addr_q  <= mem_addr_d;
      if (rf_we && rd != 5'd0) rf_q[rd] <= rf_wdata;
    end
  end

  assign o_inst_read                = inst_read_q;
  assign o_inst_read_addr           = inst_addr_q;
  assign o_master_read              = mem_read_q;
  assign o_master_read_addr         = mem_addr_q;
  assign o_master_write             = wr_en;
  assign o_master_write_addr        = wr_addr;
  assign o_master_write_data        = wr_data;
  assign o_master_write_byte_enable = wr_be;

endmodule

// File: tb/tb_orc_r32i_core.sv
// Self-checking bench for orc_r32i_core: small programs whose results are observed through stores,
// checked against a scoreboard of expected writes, with configurable fetch/load ack latency.
module tb_orc_r32i_core;

  logic        clk;
  logic        resetn;
  logic        o_inst_read;
  logic        i_inst_read_ack;
  logic [31:0] o_inst_read_addr;
  logic [31:0] i_inst_read_data;
  logic        o_master_read;
  logic        i_master_read_ack;
  logic [31:0] o_master_read_addr;
  logic [31:0] i_master_read_data;
  logic        o_master_write;
  logic        i_master_write_ack;
  logic [31:0] o_master_write_addr;
  logic [31:0] o_master_write_data;
  logic [3:0]  o_master_write_byte_enable;

  orc_r32i_core #(.P_RESET_PC(32'h0000_0000)) dut (
    .clk                        (clk),
    .resetn                     (resetn),
    .o_inst_read                (o_inst_read),
    .i_inst_read_ack            (i_inst_read_ack),
    .o_inst_read_addr           (o_inst_read_addr),
    .i_inst_read_data           (i_inst_read_data),
    .o_master_read              (o_master_read),
    .i_master_read_ack          (i_master_read_ack),
    .o_master_read_addr         (o_master_read_addr),
    .i_master_read_data         (i_master_read_data),
    .o_master_write             (o_master_write),
    .i_master_write_ack         (i_master_write_ack),
    .o_master_write_addr        (o_master_write_addr),
    .o_master_write_data        (o_master_write_data),
    .o_master_write_byte_enable (o_master_write_byte_enable)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  localparam logic [31:0] OUT = 32'h1000_0000;

  wr_t         sb[$];
  logic [7:0]  mem8 [4096];
  logic [31:0] pc_b;
  int          n_tests, n_fail;
  int          n_wr_seen, n_wr_exp, n_excl;
  int          ack_dly;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    logic [31:0] w, t;
    w = 32'h0;
    for (int k = 0; k < 4; k++) begin
      t = a + k;
      w[8*k +: 8] = mem8[t[11:0]];
    end
    return w;
  endfunction

  // Instruction encoders
  function automatic logic [31:0] f_i(input logic [31:0] imm, rs1, f3, rd, op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] f_r(input logic [31:0] f7, rs2, rs1, f3, rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] f_s(input logic [31:0] imm, rs2, rs1, f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] f_b(input logic [31:0] imm, rs1, rs2, f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] f_u(input logic [31:0] imm, rd, op);
    return {imm[19:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] f_j(input logic [31:0] imm, rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction

  task automatic emit(input logic [31:0] w);
    for (int k = 0; k < 4; k++) mem8[pc_b[11:0] + 12'(k)] = w[8*k +: 8];
    pc_b = pc_b + 32'd4;
  endtask
  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_t e;
    e.addr = a; e.data = d; e.be = be;
    sb.push_back(e);
    n_wr_exp++;
  endtask
  task automatic addi(input int rd, input int rs1, input int imm);
    emit(f_i(imm, rs1, 0, rd, 32'h13));
  endtask
  task automatic sw_chk(input int rs, input int off, input logic [31:0] exp);
    emit(f_s(off, rs, 5, 2));
    push_wr(OUT + off, exp, 4'b1111);
  endtask

  // Fetch responder: acks after ack_dly idle cycles, verifying the request is held steady.
  initial begin : fetch_mem
    int          cnt;
    logic [31:0] first;
    i_inst_read_ack = 1'b0; i_inst_read_data = 32'h0; cnt = 0; first = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (!resetn) begin
        i_inst_read_ack = 1'b0; cnt = 0;
      end else if (i_inst_read_ack) begin
        i_inst_read_ack = 1'b0;
      end else if (o_inst_read) begin
        if (cnt == 0) first = o_inst_read_addr;
        if (cnt == ack_dly) begin
          if (ack_dly > 0) chk("if_addr_stable", o_inst_read_addr, first);
          i_inst_read_data = rd_word(o_inst_read_addr);
          i_inst_read_ack  = 1'b1;
          cnt = 0;
        end else cnt++;
      end
    end
  end

  initial begin : load_mem
    int          cnt;
    logic [31:0] first;
    i_master_read_ack = 1'b0; i_master_read_data = 32'h0; cnt = 0; first = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (!resetn) begin
        i_master_read_ack = 1'b0; cnt = 0;
      end else if (i_master_read_ack) begin
        i_master_read_ack = 1'b0;
      end else if (o_master_read) begin
        if (cnt == 0) first = o_master_read_addr;
        if (cnt == ack_dly) begin
          if (ack_dly > 0) chk("ld_addr_stable", o_master_read_addr, first);
          i_master_read_data = rd_word(o_master_read_addr);
          i_master_read_ack  = 1'b1;
          cnt = 0;
        end else cnt++;
      end
    end
  end

  initial begin : wr_monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (o_inst_read && o_master_read) n_excl++;
      if (resetn && o_master_write) begin
        n_wr_seen++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("wr_addr", o_master_write_addr, e.addr);
          chk("wr_data", o_master_write_data, e.data);
          chk("wr_be", {28'h0, o_master_write_byte_enable}, {28'h0, e.be});
        end
      end
    end
  end

  task automatic new_prog();
    @(negedge clk); resetn = 1'b0;
    repeat (2) @(posedge clk);
    sb.delete();
    n_wr_seen = 0; n_wr_exp = 0; n_excl = 0;
    for (int a = 0; a < 4096; a++) mem8[a] = 8'h00;
    pc_b = 32'h0;
  endtask

  task automatic run_prog(input int dly, input int rst_cycles);
    int waited;
    ack_dly = dly;
    repeat (rst_cycles) @(posedge clk);
    @(negedge clk);
    chk("rst_inst_read", {31'h0, o_inst_read}, 32'h0);
    chk("rst_inst_addr", o_inst_read_addr, 32'h0);
    chk("rst_ld_read", {31'h0, o_master_read}, 32'h0);
    chk("rst_ld_addr", o_master_read_addr, 32'h0);
    chk("rst_wr", {31'h0, o_master_write}, 32'h0);
    chk("rst_wr_addr", o_master_write_addr, 32'h0);
    chk("rst_wr_data", o_master_write_data, 32'h0);
    resetn = 1'b1;
    waited = 0;
    while (!o_inst_read && waited < 20) begin @(negedge clk); waited++; end
    chk("first_fetch_req", {31'h0, o_inst_read}, 32'h1);
    chk("first_fetch_addr", o_inst_read_addr, 32'h0);
    waited = 0;
    while (sb.size() > 0 && waited < 8000) begin @(negedge clk); waited++; end
    chk("sb_drain", sb.size(), 0);
    repeat (40) @(negedge clk);
    chk("wr_count", n_wr_seen, n_wr_exp);
    chk("bus_excl", n_excl, 0);
  endtask

  task automatic build_alu();
    logic [31:0] p;
    new_prog();
    emit(f_u(32'h10000, 5, 32'h37));               // x5 = 0x1000_0000
    addi(1, 0, 5);
    addi(2, 1, -7);
    emit(f_r(32'h20, 2, 1, 0, 3));                 // SUB x3,x1,x2
    addi(0, 1, 9);
    sw_chk(2, 0, 32'hFFFF_FFFE);
    sw_chk(3, 0, 32'h7);
    sw_chk(0, 4, 32'h0);
    addi(6, 0, 32'h48);
    emit(f_s(0, 6, 5, 0));    push_wr(OUT, 32'h48, 4'b0001);
    emit(f_s(2, 2, 5, 1));    push_wr(OUT + 2, 32'h0000_FFFE, 4'b0011);
    addi(7, 0, -16);
    emit(f_i(32'h402, 7, 5, 8, 32'h13)); sw_chk(8, 0, 32'hFFFF_FFFC);   // SRAI
    emit(f_i(28, 7, 5, 9, 32'h13));      sw_chk(9, 0, 32'hF);           // SRLI
    emit(f_i(30, 1, 1, 9, 32'h13));      sw_chk(9, 0, 32'h4000_0000);   // SLLI
    emit(f_r(0, 1, 7, 2, 10));           sw_chk(10, 0, 32'h1);          // SLT
    emit(f_r(0, 1, 7, 3, 10));           sw_chk(10, 0, 32'h0);          // SLTU
    emit(f_i(-15, 7, 2, 10, 32'h13));    sw_chk(10, 0, 32'h1);          // SLTI
    emit(f_i(-1, 1, 3, 10, 32'h13));     sw_chk(10, 0, 32'h1);          // SLTIU
    emit(f_i(-1, 1, 4, 12, 32'h13));     sw_chk(12, 0, 32'hFFFF_FFFA);  // XORI
    emit(f_r(0, 7, 1, 6, 12));           sw_chk(12, 0, 32'hFFFF_FFF5);  // OR
    emit(f_r(0, 6, 7, 7, 12));           sw_chk(12, 0, 32'h40);         // AND
    emit(f_r(0, 1, 6, 4, 12));           sw_chk(12, 0, 32'h4D);         // XOR
    emit(f_i(32'h3C, 7, 7, 12, 32'h13)); sw_chk(12, 0, 32'h30);         // ANDI
    emit(f_i(32'h30, 1, 6, 12, 32'h13)); sw_chk(12, 0, 32'h35);         // ORI
    emit(f_r(32'h20, 1, 7, 5, 12));      sw_chk(12, 0, 32'hFFFF_FFFF);  // SRA
    emit(f_r(0, 1, 7, 5, 12));           sw_chk(12, 0, 32'h07FF_FFFF);  // SRL
    emit(f_r(0, 1, 6, 1, 12));           sw_chk(12, 0, 32'h900);        // SLL
    addi(13, 0, 33);
    emit(f_r(0, 13, 1, 1, 12));          sw_chk(12, 0, 32'hA);          // shift uses rs2[4:0]
    emit(f_r(0, 1, 7, 0, 12));           sw_chk(12, 0, 32'hFFFF_FFF5);  // ADD
    emit(f_u(32'h80000, 14, 32'h37));
    emit(f_r(0, 14, 14, 0, 12));         sw_chk(12, 0, 32'h0);          // wraps
    p = pc_b;
    emit(f_u(32'h1, 12, 32'h17));        sw_chk(12, 0, p + 32'h1000);   // AUIPC
    emit(32'h0000_0073);                                                // ECALL as NOP
    sw_chk(1, 0, 32'h5);
    emit(f_j(0, 0));
  endtask

  task automatic build_load();
    new_prog();
    emit(f_u(32'h10000, 5, 32'h37));
    emit(f_i(32'h100, 0, 0, 1, 32'h03)); sw_chk(1, 0, 32'hFFFF_FF80);   // LB
    emit(f_i(32'h100, 0, 4, 1, 32'h03)); sw_chk(1, 0, 32'h80);          // LBU
    emit(f_i(32'h100, 0, 1, 1, 32'h03)); sw_chk(1, 0, 32'hFFFF_FF80);   // LH
    emit(f_i(32'h100, 0, 5, 1, 32'h03)); sw_chk(1, 0, 32'hFF80);        // LHU
    emit(f_i(32'h100, 0, 2, 1, 32'h03)); sw_chk(1, 0, 32'h3412_FF80);   // LW
    emit(f_i(32'h101, 0, 1, 1, 32'h03)); sw_chk(1, 0, 32'h12FF);        // misaligned LH
    emit(f_i(32'h103, 0, 0, 1, 32'h03)); sw_chk(1, 0, 32'h34);
    addi(2, 0, 32'h100);
    emit(f_i(2, 2, 2, 3, 32'h03));       sw_chk(3, 0, 32'h3412);        // base register
    emit(f_i(32'h100, 0, 2, 0, 32'h03)); sw_chk(0, 0, 32'h0);           // x0 stays 0
    sw_chk(1, 1, 32'h34);                                               // misaligned store
    emit(f_j(0, 0));
    mem8[12'h100] = 8'h80; mem8[12'h101] = 8'hFF;
    mem8[12'h102] = 8'h12; mem8[12'h103] = 8'h34;
  endtask

  task automatic build_ctrl();
    logic [31:0] p;
    int f3s [9] = '{0, 1, 4, 5, 5, 6, 6, 7, 0};
    int r1s [9] = '{1, 1, 7, 7, 0, 7, 0, 7, 7};
    int r2s [9] = '{0, 0, 0, 0, 7, 0, 7, 0, 0};
    int tkn [9] = '{1, 0, 1, 0, 1, 0, 1, 1, 0};
    new_prog();
    emit(f_u(32'h10000, 5, 32'h37));
    emit(f_j(32'h3C, 0));                  // to 0x40
    pc_b = 32'h40;
    emit(f_j(8, 1));                       // JAL x1,+8
    emit(f_s(32'h10, 0, 5, 2));            // skipped
    sw_chk(1, 0, 32'h44);
    addi(1, 0, 3);
    addi(2, 0, 0);
    addi(1, 1, -1);
    addi(2, 2, 1);
    emit(f_b(-8, 1, 0, 1));                // BNE loop
    sw_chk(2, 0, 32'h3);
    sw_chk(1, 0, 32'h0);
    addi(7, 0, -16);
    for (int i = 0; i < 9; i++) begin
      addi(9, 0, 1);
      emit(f_b(8, r1s[i], r2s[i], f3s[i]));
      addi(9, 0, 2);
      sw_chk(9, 0, (tkn[i] != 0) ? 32'h1 : 32'h2);
    end
    p = pc_b;
    addi(10, 0, int'(p) + 8);
    emit(f_i(5, 10, 0, 10, 32'h67));       // JALR x10,x10,5
    emit(f_s(32'h10, 0, 5, 2));            // skipped
    sw_chk(10, 0, p + 32'h8);
    emit(f_j(0, 0));
  endtask

  initial begin
    n_tests = 0; n_fail = 0; n_wr_seen = 0; n_wr_exp = 0; n_excl = 0;
    ack_dly = 0; pc_b = 32'h0;
    resetn = 1'b0;
    i_master_write_ack = 1'b0;
    build_alu();  run_prog(0, 100);
    build_load(); run_prog(0, 5);
    build_load(); run_prog(5, 5);
    build_ctrl(); run_prog(0, 5);
    build_ctrl(); run_prog(5, 5);
    build_alu();  run_prog(2, 5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
